// File: rtl/coin_acceptor.sv
// coin_acceptor
// Front end for the vending machine coin path. Two raw, bouncy coin sensors
// (5 rs and 10 rs) are synchronised, debounced and turned into one event per
// inserted coin. Events are screened (simultaneous/overlapping coins, disabled
// acceptance, full buffer) and good coins are queued in a small FIFO. A
// sequencer replays the queue onto the vending machine input bus.
//
// Output protocol: coin_code is a single-cycle code (01 = 5 rs, 10 = 10 rs)
// followed by at least GAP_CYCLES cycles of 00, so codes start no closer than
// GAP_CYCLES+2 cycles apart. The consumer applies back-pressure with hold,
// which is only looked at before a new code starts; a started code always
// completes. There is no per-code acknowledge.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   coin5_raw      raw 5 rs sensor (asynchronous to clk)
//   coin10_raw     raw 10 rs sensor (asynchronous to clk)
//   accept_en      1 = coins may be queued, 0 = every new coin is rejected
//   hold           1 = do not start a new code (downstream busy)
//   coin_code      coin code to vending machine (never 2'b11)
//   reject         one-cycle pulse per coin that was not queued
//   jam            high while both debounced lines are high
//   fifo_level     number of queued coins, 0..FIFO_DEPTH
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coin5_raw,
  input  logic                              coin10_raw,
  input  logic                              accept_en,
  input  logic                              hold,
  output logic [1:0]                        coin_code,
  output logic                              reject,
  output logic                              jam,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Index 0 is the 5 rs line, index 1 the 10 rs line.
  logic [1:0]    raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [CW-1:0] db_cnt [2];

  assign raw = {coin10_raw, coin5_raw};

  // --------------------------------------------------------------------------
  // Synchroniser and debouncer. The counter measures how long the synced
  // value has disagreed with the debounced level; it restarts on any
  // agreement, so a bouncing line never gets through.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      deb       <= '0;
      deb_q     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= ~deb[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event detection and screening
  // --------------------------------------------------------------------------
  logic [1:0]    ev;
  logic          conflict;
  logic          fifo_full;
  logic          reject_next;
  logic          push;
  logic [1:0]    push_code;
  logic [LW-1:0] count;

  assign ev = deb & ~deb_q;
  // A coin event while the other line is debounced high is ambiguous; this
  // also covers both events landing in the same cycle, since each event
  // implies its own debounced level is high.
  assign conflict    = (ev[0] & deb[1]) | (ev[1] & deb[0]);
  // Fullness uses the registered count, so a same-cycle pop cannot make
  // room for a push.
  assign fifo_full   = (count == LW'(FIFO_DEPTH));
  assign reject_next = (|ev) & (conflict | ~accept_en | fifo_full);
  assign push        = (|ev) & ~reject_next;
  assign push_code   = ev[0] ? 2'b01 : 2'b10;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject <= 1'b0;
      jam    <= 1'b0;
    end else begin
      reject <= reject_next;
      jam    <= deb[0] & deb[1];
    end
  end

  // --------------------------------------------------------------------------
  // Coin FIFO (power-of-two depth, pointers wrap naturally)
  // --------------------------------------------------------------------------
  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;

  // --------------------------------------------------------------------------
  // Emission sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  seq_state_t    state;
  seq_state_t    state_next;
  logic [1:0]    code_next;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      coin_code <= 2'b00;
      gap_cnt   <= '0;
    end else begin
      state     <= state_next;
      coin_code <= code_next;
      gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    code_next  = 2'b00;
    case (state)
      IDLE: begin
        if ((count != '0) && !hold) begin
          pop        = 1'b1;
          code_next  = mem[rd_ptr];
          state_next = EMIT;
        end
      end
      EMIT: begin
        state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed scenarios plus randomized bouncy
// insertions, compared every cycle against a behavioural model.
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
  localparam int LW    = $clog2(DEPTH + 1);

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          coin5_raw;
  logic          coin10_raw;
  logic          accept_en;
  logic          hold;
  logic [1:0]    coin_code;
  logic          reject;
  logic          jam;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin5_raw (coin5_raw),
    .coin10_raw(coin10_raw),
    .accept_en (accept_en),
    .hold      (hold),
    .coin_code (coin_code),
    .reject    (reject),
    .jam       (jam),
    .fifo_level(fifo_level)
  );

  // --------------------------------------------------------------------------
  // Scoreboard counters and check task
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: raw samples age through a two-deep history, a line's
  // level changes once the synced sample has disagreed with it for DEB
  // samples in a row, accepted coins live in exp_q, and emissions are
  // rate-limited by a cooldown count.
  // --------------------------------------------------------------------------
  logic [1:0] exp_q[$];
  logic       m_h5 [2];
  logic       m_h10[2];
  logic       m_l5, m_l5p, m_l10, m_l10p;
  int         m_run5, m_run10;
  int         m_cool;
  logic [1:0] m_code;
  logic       m_rej, m_jam;

  task automatic model_reset();
    exp_q.delete();
    m_h5[0] = 0; m_h5[1] = 0; m_h10[0] = 0; m_h10[1] = 0;
    m_l5 = 0; m_l5p = 0; m_l10 = 0; m_l10p = 0;
    m_run5 = 0; m_run10 = 0; m_cool = 0;
    m_code = 2'b00; m_rej = 0; m_jam = 0;
  endtask

  task automatic model_edge();
    logic ev5, ev10, rej, push;
    logic [1:0] code;
    ev5  = m_l5 && !m_l5p;
    ev10 = m_l10 && !m_l10p;
    rej  = 0;
    push = 0;
    if (ev5 || ev10) begin
      if ((ev5 && ev10) || (ev5 && m_l10) || (ev10 && m_l5)) rej = 1;
      else if (!accept_en)                                    rej = 1;
      else if (exp_q.size() == DEPTH)                          rej = 1;
      else                                                     push = 1;
    end
    code = 2'b00;
    if (m_cool == 0 && exp_q.size() > 0 && !hold) begin
      code   = exp_q.pop_front();
      m_cool = GAP + 1;
    end else if (m_cool > 0) begin
      m_cool--;
    end
    if (push) exp_q.push_back(ev5 ? 2'b01 : 2'b10);
    m_code = code;
    m_rej  = rej;
    m_jam  = m_l5 && m_l10;
    m_l5p  = m_l5;
    m_l10p = m_l10;
    if (m_h5[1] != m_l5) begin
      m_run5++;
      if (m_run5 == DEB) begin m_l5 = !m_l5; m_run5 = 0; end
    end else m_run5 = 0;
    if (m_h10[1] != m_l10) begin
      m_run10++;
      if (m_run10 == DEB) begin m_l10 = !m_l10; m_run10 = 0; end
    end else m_run10 = 0;
    m_h5[1]  = m_h5[0];  m_h5[0]  = coin5_raw;
    m_h10[1] = m_h10[0]; m_h10[0] = coin10_raw;
  endtask

  // --------------------------------------------------------------------------
  // Monitors
  // --------------------------------------------------------------------------
  int n5, n10, n_rej, max_level, saw_jam;
  int start_q[$];

  task automatic clear_stats();
    n5 = 0; n10 = 0; n_rej = 0; max_level = 0; saw_jam = 0;
    start_q.delete();
  endtask

  // One clock: advance model, then compare all outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    cyc++;
    check("coin_code",  coin_code,  m_code);
    check("reject",     reject,     m_rej);
    check("jam",        jam,        m_jam);
    check("fifo_level", fifo_level, exp_q.size());
    if (coin_code == 2'b01) n5++;
    if (coin_code == 2'b10) n10++;
    if (coin_code != 2'b00) start_q.push_back(cyc);
    if (reject) n_rej++;
    if (jam) saw_jam = 1;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  endtask

  // Drive task: line bit0 = 5 rs, bit1 = 10 rs.
  task automatic insert(input int line, input int hi, input int lo);
    coin5_raw  = line[0];
    coin10_raw = line[1];
    repeat (hi) step();
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    repeat (lo) step();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit found;
    rst = 1'b1; coin5_raw = 0; coin10_raw = 0; accept_en = 1; hold = 0;
    model_reset();
    clear_stats();
    repeat (2) step();
    check("rst_code",  coin_code,  0);
    check("rst_rej",   reject,     0);
    check("rst_jam",   jam,        0);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;
    step();

    // 1: single 5 rs coin, latency to edge 7
    clear_stats();
    coin5_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 6) begin
        check("t1_code_e6",  coin_code,  2'b00);
        check("t1_level_e6", fifo_level, 1);
      end
      if (k == 7) check("t1_code_e7", coin_code, 2'b01);
      if (k == 8) check("t1_code_e8", coin_code, 2'b00);
    end
    coin5_raw = 1'b0;
    repeat (15) step();
    check("t1_n5",    n5,         1);
    check("t1_rej",   n_rej,      0);
    check("t1_max",   max_level,  1);
    check("t1_level", fifo_level, 0);

    // 2: bouncing 10 rs line, then a clean hold
    clear_stats();
    for (int k = 0; k < 12; k++) begin
      coin10_raw = ((k / 2) % 2) == 0;
      step();
    end
    insert(2, 10, 15);
    check("t2_n10", n10,   1);
    check("t2_rej", n_rej, 0);

    // 3: hold, overflow, then drain with spacing
    clear_stats();
    hold = 1'b1;
    repeat (5) insert(1, 12, 12);
    check("t3_rej",   n_rej,      1);
    check("t3_max",   max_level,  4);
    check("t3_level", fifo_level, 4);
    hold = 1'b0;
    repeat (20) step();
    check("t3_n5",    n5,             4);
    check("t3_level0", fifo_level,    0);
    check("t3_starts", start_q.size(), 4);
    for (int i = 1; i < start_q.size(); i++)
      check("t3_spacing", start_q[i] - start_q[i-1], GAP + 2);

    // 4: both lines together
    clear_stats();
    insert(3, 12, 15);
    check("t4_rej",   n_rej,      1);
    check("t4_codes", n5 + n10,   0);
    check("t4_jam",   saw_jam,    1);
    check("t4_max",   max_level,  0);

    // 5: acceptance disabled, then enabled
    clear_stats();
    accept_en = 1'b0;
    insert(2, 12, 12);
    check("t5_rej",  n_rej,     1);
    check("t5_max",  max_level, 0);
    check("t5_n10d", n10,       0);
    accept_en = 1'b1;
    clear_stats();
    insert(2, 12, 15);
    check("t5_n10",  n10,   1);
    check("t5_rej2", n_rej, 0);

    // 6: reset in the middle of draining
    clear_stats();
    hold = 1'b1;
    insert(1, 12, 12);
    insert(2, 12, 12);
    insert(1, 12, 12);
    check("t6_level3", fifo_level, 3);
    hold  = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (coin_code == 2'b01) found = 1;
    end
    check("t6_first01", found, 1);
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_rst_code",  coin_code,  0);
    check("t6_rst_level", fifo_level, 0);
    repeat (2) step();
    rst = 1'b0;
    clear_stats();
    repeat (30) step();
    check("t6_no_codes", n5 + n10, 0);

    // Random bouncy insertions with random accept_en / hold
    for (int n = 0; n < 40; n++) begin
      int line;
      accept_en = ($urandom_range(0, 4) != 0);
      hold      = ($urandom_range(0, 3) == 0);
      line      = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(1, 2);
      repeat ($urandom_range(0, 6)) begin
        coin5_raw  = line[0] & $urandom_range(0, 1);
        coin10_raw = line[1] & $urandom_range(0, 1);
        step();
      end
      coin5_raw  = line[0];
      coin10_raw = line[1];
      repeat ($urandom_range(2, 14)) step();
      repeat ($urandom_range(0, 6)) begin
        coin5_raw  = line[0] & $urandom_range(0, 1);
        coin10_raw = line[1] & $urandom_range(0, 1);
        step();
      end
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      repeat ($urandom_range(2, 16)) step();
    end
    hold = 1'b0;
    repeat (40) step();
    check("rand_drain", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage directly upstream of vending_machine. Takes raw, bouncy coin-sensor lines for 5 rs and 10 rs coins.
- Synchronises and debounces each line, detects one event per inserted coin, and screens for jams and overflow.
- Buffers accepted coins in a small FIFO and replays them onto the vending_machine `in` bus as single-cycle coin codes with a guaranteed idle gap between codes.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synced cycles required before the debounced level changes (≥1).
- FIFO_DEPTH, 4: number of queued coins (power of 2, ≥2).
- GAP_CYCLES, 1: forced 2'b00 cycles after each emitted code (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- coin5_raw  in  1  raw 5 rs sensor, asynchronous to clk.
- coin10_raw  in  1  raw 10 rs sensor, asynchronous to clk.
- accept_en  in  1  1 = coins may be queued; 0 = every new coin is rejected.
- hold  in  1  1 = sequencer starts no new emission (downstream busy).
- coin_code  out  2  drives vending_machine `in`: 2'b01 = 5 rs, 2'b10 = 10 rs, 2'b00 = none; 2'b11 is never driven.
- reject  out  1  one-cycle pulse per coin not queued (mechanical return).
- jam  out  1  level; 1 while both debounced lines are high.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  queued coin count, 0..FIFO_DEPTH.

Behaviour:
- Reset (async, rst=1): all outputs 0, sync/debounce registers 0, FIFO emptied, sequencer IDLE. Reset mid-operation discards queued coins; nothing is emitted for them.
- After reset, a raw line still held high is a new coin once debounced.
- Sync: 2-flop synchroniser per raw line.
- Debounce, per line:
  - Counter increments while synced value ≠ debounced level; clears when they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Event: registered rising edge of a debounced level (1-cycle pulse). Falling edges are ignored.
- Screening of an event cycle, in priority order:
  1. Both events in the same cycle, or an event while the other debounced level is high: one reject pulse, nothing queued.
  2. accept_en=0: reject.
  3. FIFO full, judged on the registered count before any same-cycle pop: reject.
  4. Otherwise push the code.
- reject asserts the cycle after the event cycle.
- jam = debounced5 & debounced10, registered.
- Sequencer states IDLE, EMIT, GAP:
  - IDLE: if FIFO non-empty and hold=0, pop the head, register it onto coin_code, go to EMIT. Otherwise coin_code = 00.
  - EMIT: lasts exactly one cycle; coin_code = popped code. Next state is GAP.
  - GAP: coin_code = 00 for GAP_CYCLES cycles, then IDLE.
  - hold is sampled only in IDLE; an emission in progress always completes.
- Spacing: minimum start-to-start spacing between codes is GAP_CYCLES+2 cycles.
- Ordering: emission order equals acceptance order. accept_en does not affect draining.
- Latency, from an empty, idle, unheld pipe. Edge 0 is the first clk edge sampling raw=1.
  - Debounced level rises after edge 1+DEBOUNCE_CYCLES.
  - Push occurs at edge 2+DEBOUNCE_CYCLES.
  - coin_code is valid for the one cycle following edge 3+DEBOUNCE_CYCLES (edge 7 at defaults).
- FIFO: pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop with 0 < level < FIFO_DEPTH leaves the level unchanged.

Test Plan:
1. coin5_raw high for 12 cycles, defaults: coin_code=01 for exactly one cycle after edge 7, fifo_level 0→1→0, reject never asserted.
2. coin10_raw toggles every 2 cycles for 12 cycles, then held high for 10 cycles: exactly one coin_code=10, no reject.
3. hold=1, five coin5 insertions each 12 cycles high/12 low: fifo_level reaches 4, the 5th produces one reject pulse. Drop hold: four 01 codes, starts 3 cycles apart, each followed by 00, fifo_level ends at 0.
4. coin5_raw and coin10_raw rise together and are held 12 cycles: jam=1 while both are debounced high, exactly one reject pulse, no code emitted, fifo_level stays 0.
5. accept_en=0, coin10 inserted: reject pulse after the event cycle, fifo_level stays 0. Same coin with accept_en=1: coin_code=10 emitted.
6. hold=1, queue three coins (01, 10, 01), drop hold, assert rst one cycle after the first 01 is emitted: coin_code=00 and fifo_level=0 immediately; no further codes emitted once raw lines are low.
